button_event_classifier: RTL and testbench
==========================================

Name: button_event_classifier

Overview:
- Consumes the debounced button level and classifies each gesture into single-cycle event pulses: press, release, short press, long press, auto-repeat and double click.
- Sits directly downstream of the button debouncer, one instance per button.
- Drives the seven-segment display controller's mode and digit-edit logic.
- Purely synchronous to clk; btn_level is already clean and synchronous.

Parameters:
- LONG_CYC, 50_000_000, cycles held before a press counts as long (0.5 s at 100 MHz).
- DCLICK_CYC, 25_000_000, window after release in which a second press makes a double click.
- REPEAT_CYC, 10_000_000, repeat_pulse period while long-held.
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(LONG_CYC, DCLICK_CYC, REPEAT_CYC).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  classifier enable; low forces idle
- btn_level  input  1  debounced button level, 1 = pressed
- press_pulse  output  1  one-cycle pulse on each press
- release_pulse  output  1  one-cycle pulse on each release
- short_press  output  1  one-cycle pulse: single short press confirmed
- long_press  output  1  one-cycle pulse: hold reached LONG_CYC
- repeat_pulse  output  1  periodic pulse while long-held
- double_click  output  1  one-cycle pulse on the second press of a double click
- long_held  output  1  level, high while in LONG state

Behaviour:
- Reset is asynchronous, active-high, on rst, clock clk.
- Reset state: state=IDLE, cnt=0, btn_d=0, every output 0.
- A button held through reset release is seen as a new press.
- Edge detect: btn_d <= btn_level every cycle.
  - rise = btn_level & ~btn_d; fall = ~btn_level & btn_d.
  - press_pulse and release_pulse are the registered rise and fall: high for the cycle after the sampling edge.
- All event outputs are registered single-cycle pulses, never high two consecutive cycles, except long_held.
- FSM states: IDLE, PRESS1, WAIT2, HOLD2, LONG.
- IDLE:
  - rise -> PRESS1, cnt<=0.
- PRESS1:
  - btn_level low -> WAIT2, cnt<=0.
  - else if cnt==LONG_CYC-1 -> LONG, cnt<=0, long_press<=1.
  - else cnt++.
  - Release wins over timeout on the same edge: that gesture is short, not long.
- WAIT2:
  - rise -> HOLD2, double_click<=1.
  - else if cnt==DCLICK_CYC-1 -> IDLE, short_press<=1.
  - else cnt++.
  - A rise on the timeout edge wins: double click.
- HOLD2:
  - Wait for btn_level low -> IDLE.
  - Hold duration is ignored: no long_press, no repeat.
- LONG:
  - long_held=1.
  - btn_level low -> IDLE; no short_press.
  - else if cnt==REPEAT_CYC-1 -> repeat_pulse<=1, cnt<=0.
  - else cnt++.
- Latency:
  - short_press registers at the DCLICK_CYC-th edge after the edge that samples release.
  - long_press registers at the LONG_CYC-th edge after the edge that samples press.
  - The k-th repeat registers at the LONG_CYC + k*REPEAT_CYC-th edge after the press edge.
- en low:
  - State forced to IDLE, cnt cleared.
  - All event outputs 0, including press_pulse and release_pulse.
  - btn_d keeps tracking btn_level, so no spurious edge when en rises.
  - en deasserting mid-gesture abandons it silently.
- Counter never wraps; it is cleared on every state change.
- Unused pulses remain harmless if downstream ignores them.

Decomposition:
- Shared include/package: FSM state encodings (3-bit localparams) and the default timing constants.
- Timing constants are reused by the display controller and the debouncer instances.
- One natural sub-module: edge_detect (btn_d register, rise/fall outputs). It is reusable for other buttons and switches.

Test Plan:
All scenarios use LONG_CYC=20, DCLICK_CYC=10, REPEAT_CYC=5.
1. Short press: btn high 5 cycles, then low -> press_pulse once, release_pulse once; short_press exactly 10 edges after release sampled; nothing else.
2. Long press with repeat: btn high 40 cycles -> long_press at edge 20 after press, repeat_pulse at edges 25, 30, 35, long_held high from edge 20 until release; no short_press.
3. Double click: press 3, release 4, press 3 -> double_click on the edge after the second press is sampled; no short_press, no long_press.
4. Boundaries:
   - Release sampled on PRESS1 cnt==19 -> short path, no long_press.
   - Second press sampled at WAIT2 cnt==9 -> double_click, no short_press.
5. Reset mid-LONG: assert rst asynchronously between edges -> all outputs 0 immediately; after rst drops with btn held -> press_pulse and a new gesture.
6. en low during PRESS1 for 3 cycles, then high with btn still held -> no events until a fresh release/press; no spurious press_pulse.

Source files
------------

// File: rtl/button_event_classifier_pkg.sv
// Shared definitions for the button event classifier.
// Holds the FSM state encodings, the default timing constants and the
// event bundle type. The debouncer and the display controller reuse the
// same timing constants, so they live here and not in the classifier.
package button_event_classifier_pkg;

  // Default timing at 100 MHz.
  localparam int LONG_CYC_DEF   = 50_000_000;  // 0.5 s hold counts as a long press
  localparam int DCLICK_CYC_DEF = 25_000_000;  // double-click window after release
  localparam int REPEAT_CYC_DEF = 10_000_000;  // auto-repeat period while long-held
  localparam int CNT_W_DEF      = 26;          // 2^26 > 50e6

  // Gesture FSM encodings.
  localparam logic [2:0] S_IDLE   = 3'd0;  // waiting for a press
  localparam logic [2:0] S_PRESS1 = 3'd1;  // first press held, timing toward long
  localparam logic [2:0] S_WAIT2  = 3'd2;  // released, waiting for a second press
  localparam logic [2:0] S_HOLD2  = 3'd3;  // second press of a double click held
  localparam logic [2:0] S_LONG   = 3'd4;  // long hold, auto-repeating

  // One-cycle event pulses, registered together.
  typedef struct packed {
    logic press;
    logic rls;
    logic shrt;
    logic lng;
    logic rpt;
    logic dclk;
  } evt_t;

endpackage

// File: rtl/button_event_classifier_edge_detect.sv
// Level edge detector for a clean, synchronous input.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   level_i   - sampled level
//   rise_o    - level_i high now, low on the previous cycle (combinational)
//   fall_o    - level_i low now, high on the previous cycle (combinational)
// The history register resets to 0, so an input already high when reset
// releases is reported as a rising edge.
module button_event_classifier_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o,
  output logic fall_o
);

  logic lvl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= level_i;
  end

  assign rise_o = level_i & ~lvl_q;
  assign fall_o = ~level_i & lvl_q;

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into single-cycle event pulses.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   en             - enable; low forces the FSM idle and silences events
//   btn_level      - debounced level, 1 = pressed
//   press_pulse    - pulse on each press
//   release_pulse  - pulse on each release
//   short_press    - pulse once a single short press is confirmed
//   long_press     - pulse when a hold reaches LONG_CYC
//   repeat_pulse   - periodic pulse every REPEAT_CYC while long-held
//   double_click   - pulse on the second press of a double click
//   long_held      - level, high while in the long-hold state
// All pulses are registered and last exactly one cycle.
module button_event_classifier
  import button_event_classifier_pkg::*;
#(
  parameter int LONG_CYC   = LONG_CYC_DEF,
  parameter int DCLICK_CYC = DCLICK_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic long_held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  logic             rise, fall;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  evt_t             ev_q, ev_d;

  // Edge history keeps tracking while disabled, so re-enabling with the
  // button held does not fabricate a press.
  button_event_classifier_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (btn_level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_d    = '0;
    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      ev_d.press = rise;
      ev_d.rls   = fall;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d = S_PRESS1;
            cnt_d   = '0;
          end
        end
        S_PRESS1: begin
          // Release is checked first: a release on the timeout edge is short.
          if (!btn_level) begin
            state_d = S_WAIT2;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            state_d  = S_LONG;
            cnt_d    = '0;
            ev_d.lng = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT2: begin
          // A second press on the timeout edge still counts as a double click.
          if (rise) begin
            state_d   = S_HOLD2;
            cnt_d     = '0;
            ev_d.dclk = 1'b1;
          end else if (cnt_q == DCLICK_LAST) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            ev_d.shrt = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HOLD2: begin
          // Hold length after a double click is deliberately ignored.
          if (!btn_level) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_LONG: begin
          if (!btn_level) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == REPEAT_LAST) begin
            cnt_d    = '0;
            ev_d.rpt = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  assign press_pulse   = ev_q.press;
  assign release_pulse = ev_q.rls;
  assign short_press   = ev_q.shrt;
  assign long_press    = ev_q.lng;
  assign repeat_pulse  = ev_q.rpt;
  assign double_click  = ev_q.dclk;
  assign long_held     = (state_q == S_LONG);

endmodule

// File: tb/tb_button_event_classifier.sv
module tb_button_event_classifier;

  localparam int LC = 20;
  localparam int DC = 10;
  localparam int RC = 5;

  // Gesture phases of the reference model.
  localparam int P_IDLE = 0, P_HELD1 = 1, P_GAP = 2, P_HELD2 = 3, P_LONG = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic btn = 1'b0;
  logic press_pulse, release_pulse, short_press, long_press;
  logic repeat_pulse, double_click, long_held;

  always #5 clk = ~clk;

  button_event_classifier #(
    .LONG_CYC   (LC),
    .DCLICK_CYC (DC),
    .REPEAT_CYC (RC),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .btn_level     (btn),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .double_click  (double_click),
    .long_held     (long_held)
  );

  // bit order: press, release, short, long, repeat, dclick, long_held
  logic [6:0] act_v;
  assign act_v = {press_pulse, release_pulse, short_press, long_press,
                  repeat_pulse, double_click, long_held};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: gesture tracked by phase and the edge index at which
  // the phase began; timeouts are elapsed-edge arithmetic.
  logic [6:0] exp_v;
  logic       m_prev;
  int         m_ph, m_t0, m_n;
  int         n_ev[7];

  task automatic model_reset();
    m_prev = 1'b0;
    m_ph   = P_IDLE;
    m_t0   = 0;
    exp_v  = '0;
  endtask

  // Predicts outputs after the next clock edge, which samples b and e.
  task automatic model_step(input logic b, input logic e);
    logic r, f;
    r      = b & ~m_prev;
    f      = ~b & m_prev;
    m_prev = b;
    exp_v  = '0;
    if (!e) begin
      m_ph = P_IDLE;
    end else begin
      exp_v[6] = r;
      exp_v[5] = f;
      case (m_ph)
        P_IDLE:  if (r) begin m_ph = P_HELD1; m_t0 = m_n; end
        P_HELD1: begin
          if (!b) begin m_ph = P_GAP; m_t0 = m_n; end
          else if (m_n - m_t0 == LC) begin exp_v[3] = 1'b1; m_ph = P_LONG; m_t0 = m_n; end
        end
        P_GAP: begin
          if (r) begin exp_v[1] = 1'b1; m_ph = P_HELD2; end
          else if (m_n - m_t0 == DC) begin exp_v[4] = 1'b1; m_ph = P_IDLE; end
        end
        P_HELD2: if (!b) m_ph = P_IDLE;
        P_LONG: begin
          if (!b) m_ph = P_IDLE;
          else if ((m_n - m_t0) % RC == 0) exp_v[2] = 1'b1;
        end
        default: m_ph = P_IDLE;
      endcase
    end
    exp_v[0] = (m_ph == P_LONG);
    m_n++;
  endtask

  // One cycle: check the result of the previous edge, then drive new inputs.
  task automatic cyc(input logic b, input logic e);
    @(negedge clk);
    chk("outs", 32'(act_v), 32'(exp_v));
    for (int i = 0; i < 7; i++) if (act_v[i]) n_ev[i]++;
    btn = b;
    en  = e;
    model_step(b, e);
  endtask

  task automatic hold(input logic b, input logic e, input int k);
    for (int i = 0; i < k; i++) cyc(b, e);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 7; i++) n_ev[i] = 0;
  endtask

  // Packs pulse counts as hex digits: press, release, short, long, repeat, dclick.
  task automatic chk_counts(input string tag, input logic [23:0] exp);
    logic [23:0] got;
    got = {4'(n_ev[6]), 4'(n_ev[5]), 4'(n_ev[4]), 4'(n_ev[3]), 4'(n_ev[2]), 4'(n_ev[1])};
    chk(tag, 32'(got), 32'(exp));
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    @(posedge clk);
    #1;
    chk("pre_rst", 32'(act_v), 32'(exp_v));
    #1 rst = 1'b1;
    #1 chk("rst_async", 32'(act_v), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_step(btn, en);
  endtask

  initial begin
    logic b;
    int   len;
    m_n = 0;
    model_reset();
    clr_counts();
    #1 rst = 1'b1;
    #2 chk("reset", 32'(act_v), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    btn = 1'b0;
    model_step(1'b0, 1'b1);
    hold(1'b0, 1'b1, 3);

    // 1. short press
    clr_counts(); hold(1'b1, 1'b1, 5); hold(1'b0, 1'b1, 15);
    chk_counts("short", 24'h111000);
    // 2. long press with repeats
    clr_counts(); hold(1'b1, 1'b1, 40); hold(1'b0, 1'b1, 15);
    chk_counts("long_rpt", 24'h110130);
    // 3. double click
    clr_counts(); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 4); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 15);
    chk_counts("dclick", 24'h220001);
    // 4. boundaries: release on the long timeout edge, just after it
    clr_counts(); hold(1'b1, 1'b1, 20); hold(1'b0, 1'b1, 15);
    chk_counts("bnd_rel19", 24'h111000);
    clr_counts(); hold(1'b1, 1'b1, 21); hold(1'b0, 1'b1, 15);
    chk_counts("bnd_rel20", 24'h110100);
    // second press on the window timeout edge, and one edge later
    clr_counts(); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 10); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 15);
    chk_counts("bnd_dc9", 24'h220001);
    clr_counts(); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 11); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 15);
    chk_counts("bnd_dc10", 24'h222000);
    // 5. reset mid-LONG with the button held: a new press follows
    hold(1'b1, 1'b1, 30);
    async_reset();
    clr_counts(); hold(1'b1, 1'b1, 25); hold(1'b0, 1'b1, 15);
    chk_counts("rst_repress", 24'h110110);
    // 6. en low during the first press: gesture abandoned, no false press
    clr_counts(); hold(1'b1, 1'b1, 5); hold(1'b1, 1'b0, 3); hold(1'b1, 1'b1, 25); hold(1'b0, 1'b1, 15);
    chk_counts("en_abandon", 24'h110000);

    // Randomized gestures, biased toward the timeout boundaries.
    b = 1'b0;
    for (int s = 0; s < 250; s++) begin
      b = ~b;
      case ($urandom_range(0, 3))
        0:       len = $urandom_range(1, 4);
        1:       len = $urandom_range(DC - 1, DC + 1);
        2:       len = $urandom_range(LC - 1, LC + 1);
        default: len = $urandom_range(LC + 2, LC + 3 * RC);
      endcase
      if ($urandom_range(0, 9) == 0) hold(b, 1'b0, $urandom_range(1, 4));
      hold(b, 1'b1, len);
      if ($urandom_range(0, 39) == 0) async_reset();
    end
    hold(1'b0, 1'b1, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
